// File: rtl/instr_fetch_mem.sv
// Instruction store with a program-load port and a valid/ready fetch port.
// Each accepted fetch goes into a single response register. Fetches outside the loaded program return NOP_INSTR with rsp_err set.
module instr_fetch_mem #(
  parameter int                 INSTR_W   = 8,
  parameter int                 ADDR_W    = 4,
  parameter int                 DEPTH     = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ld_en,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [INSTR_W-1:0] ld_data,
  input  logic               req_valid,
  input  logic [ADDR_W-1:0]  req_addr,
  output logic               req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [INSTR_W-1:0] rsp_instr,
  output logic               rsp_err,
  output logic [ADDR_W:0]    prog_len
);

  // Comparisons are done at ADDR_W+1 bits so that DEPTH = 2**ADDR_W and ld_addr+1 never wrap.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = {{ADDR_W{1'b0}}, 1'b1};

  logic [INSTR_W-1:0] mem_r [DEPTH];
  logic [ADDR_W:0]    prog_len_r;
  logic               rsp_valid_r;
  logic [INSTR_W-1:0] rsp_instr_r;
  logic               rsp_err_r;

  logic               req_ready_s;
  logic               fire_s;
  logic               ld_ok_s;
  logic [ADDR_W:0]    ld_end_s;
  logic               fetch_ok_s;
  logic [INSTR_W-1:0] rd_word_s;

  // Handshake, load qualification and fetch address decode.
  always_comb begin
    req_ready_s = (!rsp_valid_r || rsp_ready) && !ld_en && !rst;
    fire_s      = req_valid && req_ready_s;
    ld_ok_s     = ld_en && !rst && ({1'b0, ld_addr} < DEPTH_L);
    ld_end_s    = {1'b0, ld_addr} + ONE_L;
    fetch_ok_s  = ({1'b0, req_addr} < DEPTH_L) && ({1'b0, req_addr} < prog_len_r);
    if (fetch_ok_s) begin
      rd_word_s = mem_r[req_addr];
    end else begin
      rd_word_s = NOP_INSTR;
    end
  end

  // Program storage; reset does not clear it, prog_len gates visibility instead.
  always_ff @(posedge clk) begin
    if (ld_ok_s) begin
      mem_r[ld_addr] <= ld_data;
    end
  end

  // Program length tracks the highest loaded address plus one.
  always_ff @(posedge clk) begin
    if (rst) begin
      prog_len_r <= {(ADDR_W+1){1'b0}};
    end else if (ld_ok_s && (ld_end_s > prog_len_r)) begin
      prog_len_r <= ld_end_s;
    end
  end

  // Response register: loads on accept, holds under back-pressure, drains on consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_instr_r <= NOP_INSTR;
      rsp_err_r   <= 1'b0;
    end else if (fire_s) begin
      rsp_valid_r <= 1'b1;
      rsp_instr_r <= rd_word_s;
      rsp_err_r   <= !fetch_ok_s;
    end else if (rsp_valid_r && rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_instr = rsp_instr_r;
  assign rsp_err   = rsp_err_r;
  assign prog_len  = prog_len_r;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed and random checks of instr_fetch_mem (DEPTH=12, ADDR_W=4).
// The expected values come from an abstract reference model of the program store and the response slot.
module tb_instr_fetch_mem;
  localparam int IW = 8;
  localparam int AW = 4;
  localparam int DP = 12;
  localparam logic [IW-1:0] NOP = 8'h00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, ld_en, req_valid, rsp_ready;
  logic [AW-1:0] ld_addr, req_addr;
  logic [IW-1:0] ld_data;
  wire           req_ready, rsp_valid, rsp_err;
  wire  [IW-1:0] rsp_instr;
  wire  [AW:0]   prog_len;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [IW-1:0] m_mem   [16];
  bit            m_known [16];
  int            m_len   = 0;
  bit            m_valid = 1'b0;
  logic [IW-1:0] m_instr = 8'h00;
  bit            m_err   = 1'b0;
  bit            m_ikn   = 1'b1;
  bit            m_show  = 1'b0;

  instr_fetch_mem #(.INSTR_W(IW), .ADDR_W(AW), .DEPTH(DP), .NOP_INSTR(NOP)) u_dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_err(rsp_err), .prog_len(prog_len)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: check req_ready mid-cycle, advance the model, check the outputs after the edge.
  task automatic tick();
    bit exp_rdy;
    bit fire;
    int a;
    @(negedge clk);
    exp_rdy = (!m_valid || rsp_ready) && !ld_en && !rst;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    fire = req_valid && exp_rdy;
    if (rst) begin
      m_valid = 1'b0; m_err = 1'b0; m_instr = NOP; m_len = 0; m_show = 1'b1; m_ikn = 1'b1;
    end else begin
      m_show = 1'b0;
      if (fire) begin
        a = int'(req_addr);
        m_valid = 1'b1;
        if (a < DP && a < m_len) begin
          m_err = 1'b0; m_instr = m_mem[a]; m_ikn = m_known[a];
        end else begin
          m_err = 1'b1; m_instr = NOP; m_ikn = 1'b1;
        end
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
      if (ld_en && int'(ld_addr) < DP) begin
        m_mem[ld_addr]   = ld_data;
        m_known[ld_addr] = 1'b1;
        if (int'(ld_addr) + 1 > m_len) m_len = int'(ld_addr) + 1;
      end
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("prog_len", 32'(prog_len), 32'(m_len));
    if (m_valid || m_show) begin
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
      if (m_ikn) chk("rsp_instr", 32'(rsp_instr), 32'(m_instr));
    end
  endtask

  task automatic drive(input bit r, input bit le, input int la, input int lv,
                       input bit rv, input int ra, input bit rr);
    rst = r; ld_en = le; ld_addr = AW'(la); ld_data = IW'(lv);
    req_valid = rv; req_addr = AW'(ra); rsp_ready = rr;
    tick();
  endtask

  initial begin
    int prog [8];
    prog = '{8'hFE, 8'hF1, 8'h00, 8'hFF, 8'hAA, 8'hBB, 8'hCC, 8'h01};
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = 8'h00;
      m_known[i] = 1'b0;
    end

    drive(1, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 1);
    // fetch before any load is an error returning NOP
    drive(0, 0, 0, 0, 1, 3, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) drive(0, 1, i, prog[i], i == 2, i, 1);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 1, i, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    // sparse load extends prog_len past an unloaded hole
    drive(0, 1, 9, 8'h1F, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 8, 1);
    drive(0, 0, 0, 0, 1, 10, 1);
    drive(0, 0, 0, 0, 1, 9, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    // back-pressure holds the response and blocks new requests
    drive(0, 0, 0, 0, 1, 4, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 6, 0);
    drive(0, 0, 0, 0, 1, 6, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    // load wins over fetch, then read-after-write
    drive(0, 1, 5, 8'h77, 1, 5, 1);
    drive(0, 0, 0, 0, 1, 5, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    // loads at or beyond DEPTH are ignored; top valid address extends prog_len to DEPTH
    drive(0, 1, 13, 8'h3C, 0, 0, 1);
    drive(0, 1, 12, 8'h3D, 0, 0, 1);
    drive(0, 1, 15, 8'h3E, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 12, 1);
    drive(0, 0, 0, 0, 1, 11, 1);
    drive(0, 1, 11, 8'h5A, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 11, 1);
    drive(0, 0, 0, 0, 1, 15, 1);
    // reset with a pending response and a load asserted
    drive(0, 0, 0, 0, 1, 1, 0);
    drive(1, 1, 0, 8'h55, 1, 1, 0);
    drive(0, 0, 0, 0, 1, 0, 1);
    drive(0, 1, 2, 8'h66, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 1, 2, 1);
    drive(0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15),
            $urandom_range(0, 255), $urandom_range(0, 1) == 1, $urandom_range(0, 15),
            $urandom_range(0, 3) != 0);
    end
    drive(0, 0, 0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
